div32_ctrl: RTL



---
 rtl/div32_ctrl_pkg.sv | 18 +
 rtl/div32_ctrl_div32u.sv | 28 ++
 rtl/div32_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/div32_ctrl_pkg.sv
// Shared opcode and FSM encodings for the multicycle divide sequencer.
package div32_ctrl_pkg;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    DIVC_IDLE = 2'b00,
    DIVC_CALC = 2'b01,
    DIVC_DONE = 2'b10
  } divc_state_t;

  localparam logic [31:0] INT_MIN = 32'h8000_0000;
  localparam logic [31:0] ALL_ONE = 32'hFFFF_FFFF;

endpackage

// File: rtl/div32_ctrl_div32u.sv
// Combinational unsigned 32-bit restoring divider; driven from stable
// registers and sampled only after a multicycle settling window.
module div32_ctrl_div32u (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] q,
  output logic [31:0] r
);

  logic [32:0] rem_w;
  logic [31:0] quo_w;

  always_comb begin
    rem_w = '0;
    quo_w = '0;
    for (int i = 31; i >= 0; i--) begin
      rem_w = {rem_w[31:0], a[i]};
      if (rem_w >= {1'b0, b}) begin
        rem_w    = rem_w - {1'b0, b};
        quo_w[i] = 1'b1;
      end
    end
  end

  assign q = quo_w;
  assign r = rem_w[31:0];

endmodule

// File: rtl/div32_ctrl.sv
// RISC-V DIV/DIVU/REM/REMU sequencer: captures operands, holds magnitudes
// on the divider for WAIT_CYC cycles, then applies sign and special cases.
module div32_ctrl
  import div32_ctrl_pkg::*;
#(
  parameter int WAIT_CYC = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  op,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result
);

  divc_state_t state;
  logic [7:0]  cnt;
  logic        want_rem_p0;
  logic        sa_p0;
  logic        sb_p0;
  logic [31:0] mag_a_p0;
  logic [31:0] mag_b_p0;
  logic [31:0] quo;
  logic [31:0] rem;

  logic        is_signed;
  logic        sa;
  logic        sb;
  logic        dz;
  logic        ovf;

  assign is_signed = ~op[0];
  assign sa        = op1[31] & is_signed;
  assign sb        = op2[31] & is_signed;
  assign dz        = (op2 == '0);
  assign ovf       = is_signed & (op1 == INT_MIN) & (op2 == ALL_ONE);
  assign in_ready  = (state == DIVC_IDLE);

  div32_ctrl_div32u u_div (
    .a (mag_a_p0),
    .b (mag_b_p0),
    .q (quo),
    .r (rem)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= DIVC_IDLE;
      cnt         <= '0;
      out_valid   <= 1'b0;
      result      <= '0;
      want_rem_p0 <= 1'b0;
      sa_p0       <= 1'b0;
      sb_p0       <= 1'b0;
      mag_a_p0    <= '0;
      mag_b_p0    <= '0;
    end else if (flush) begin
      state     <= DIVC_IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        // p0: operand capture, magnitudes and special-case bypass
        DIVC_IDLE: begin
          if (in_valid) begin
            want_rem_p0 <= op[1];
            sa_p0       <= sa;
            sb_p0       <= sb;
            mag_a_p0    <= sa ? (~op1 + 32'd1) : op1;
            mag_b_p0    <= sb ? (~op2 + 32'd1) : op2;
            if (dz) begin
              result    <= op[1] ? op1 : ALL_ONE;
              out_valid <= 1'b1;
              state     <= DIVC_DONE;
            end else if (ovf) begin
              result    <= op[1] ? 32'h0 : INT_MIN;
              out_valid <= 1'b1;
              state     <= DIVC_DONE;
            end else begin
              cnt   <= 8'(WAIT_CYC - 1);
              state <= DIVC_CALC;
            end
          end
        end
        // p1: divider settles; sample and sign-correct on the last cycle
        DIVC_CALC: begin
          if (cnt == 8'd0) begin
            if (want_rem_p0)
              result <= sa_p0 ? (~rem + 32'd1) : rem;
            else
              result <= (sa_p0 ^ sb_p0) ? (~quo + 32'd1) : quo;
            out_valid <= 1'b1;
            state     <= DIVC_DONE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        // p2: hold result until the consumer takes it
        DIVC_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= DIVC_IDLE;
          end
        end
        default: begin
          state     <= DIVC_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
